// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment capture path.
package seg7_pkg;

  localparam logic [6:0] SEG7_0     = 7'b0111111;
  localparam logic [6:0] SEG7_1     = 7'b0000110;
  localparam logic [6:0] SEG7_2     = 7'b1011011;
  localparam logic [6:0] SEG7_3     = 7'b1001111;
  localparam logic [6:0] SEG7_4     = 7'b1100110;
  localparam logic [6:0] SEG7_5     = 7'b1101101;
  localparam logic [6:0] SEG7_6     = 7'b1111100;
  localparam logic [6:0] SEG7_7     = 7'b0000111;
  localparam logic [6:0] SEG7_8     = 7'b1111111;
  localparam logic [6:0] SEG7_9     = 7'b1100111;
  localparam logic [6:0] SEG7_BLANK = 7'b0000000;

  localparam logic [3:0] SEL_MIN_U = 4'b0001;
  localparam logic [3:0] SEL_MIN_D = 4'b0010;
  localparam logic [3:0] SEL_HRS_U = 4'b0100;
  localparam logic [3:0] SEL_HRS_D = 4'b1000;

  typedef struct packed {
    logic [3:0] hrs_d;
    logic [3:0] hrs_u;
    logic [3:0] min_d;
    logic [3:0] min_u;
  } bcd_time_t;

  // A frame is a plausible wall-clock time: 00:00 .. 23:59
  function automatic logic time_in_range(input bcd_time_t t);
    return (t.min_d <= 4'd5) && (t.min_u <= 4'd9) &&
           ((t.hrs_d < 4'd2) || ((t.hrs_d == 4'd2) && (t.hrs_u <= 4'd3)));
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph decoder: 7-segment pattern to {valid, BCD digit}.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] digit
);

  // Map each lit-segment pattern to its digit; anything else is invalid
  always_comb begin
    valid = 1'b1;
    digit = 4'd0;
    case (seg)
      SEG7_0:  digit = 4'd0;
      SEG7_1:  digit = 4'd1;
      SEG7_2:  digit = 4'd2;
      SEG7_3:  digit = 4'd3;
      SEG7_4:  digit = 4'd4;
      SEG7_5:  digit = 4'd5;
      SEG7_6:  digit = 4'd6;
      SEG7_7:  digit = 4'd7;
      SEG7_8:  digit = 4'd8;
      SEG7_9:  digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_mux_capture.sv
// Reads back a scanned HH:MM display and publishes frames once they repeat.
// Optional SEG7_CAPTURE_DP_EN adds per-digit decimal-point capture on `dots`.
module seg7_mux_capture
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int STABLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic       dp_in,
  input  logic [3:0] sel_in,
  input  logic       seg_active_low,
  input  logic       sel_active_low,
  output logic [3:0] min_u,
  output logic [3:0] min_d,
  output logic [3:0] hrs_u,
  output logic [3:0] hrs_d,
`ifdef SEG7_CAPTURE_DP_EN
  output logic [3:0] dots,
`endif
  output logic       time_valid,
  output logic       update,
  output logic       err_glyph,
  output logic       err_sel
);

  localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]      SETTLE_MAX = 8'(SETTLE_CYCLES);
  localparam logic [2:0]      STABLE_MIN = 3'(STABLE_FRAMES);
  localparam logic [TW-1:0]   TMO_MAX    = TW'(TIMEOUT_CYCLES);

  logic [11:0]   raw_s, sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [7:0]    settle_q, settle_d;
  logic          sampled_q, sampled_d;
  logic [3:0]    seen_q, seen_d;
  logic          bad_q, bad_d;
  bcd_time_t     frame_q, frame_d, shadow_q, shadow_d, out_q, out_d;
  logic [2:0]    match_q, match_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          valid_q, valid_d, update_q, update_d;
  logic          err_glyph_q, err_glyph_d, err_sel_q, err_sel_d;
  logic [3:0]    sel_s, digit_s;
  logic [6:0]    seg_s;
  logic          chg_s, sample_s, onehot_s, glyph_ok_s;
  logic          complete_s, good_s, same_s, diff_s;
`ifdef SEG7_CAPTURE_DP_EN
  logic [3:0]    dfrm_q, dfrm_d, dshadow_q, dshadow_d, dout_q, dout_d;
`endif

  assign raw_s = {sel_in ^ {4{sel_active_low}}, seg_in ^ {7{seg_active_low}},
                  dp_in ^ seg_active_low};
  assign sel_s = sync2_q[11:8];
  assign seg_s = sync2_q[7:1];

  seg7_decode u_decode (.seg(seg_s), .valid(glyph_ok_s), .digit(digit_s));

  // Next-state logic: settle/sample, frame assembly, stability, publish, timeout
  always_comb begin
    sync1_d = raw_s;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    chg_s   = (sync2_q != prev_q);

    if (chg_s)                        settle_d = 8'd0;
    else if (settle_q != SETTLE_MAX)  settle_d = settle_q + 8'd1;
    else                              settle_d = settle_q;

    sample_s = !chg_s && (settle_q == SETTLE_MAX) && !sampled_q;
    // Only a selector change re-arms sampling, not a glyph change on the same slot
    if (sel_s != prev_q[11:8]) sampled_d = 1'b0;
    else if (sample_s)         sampled_d = 1'b1;
    else                       sampled_d = sampled_q;

    case (sel_s)
      SEL_MIN_U, SEL_MIN_D, SEL_HRS_U, SEL_HRS_D: onehot_s = 1'b1;
      default:                                    onehot_s = 1'b0;
    endcase

    frame_d     = frame_q;
    seen_d      = seen_q;
    bad_d       = bad_q;
    err_glyph_d = 1'b0;
    err_sel_d   = 1'b0;
`ifdef SEG7_CAPTURE_DP_EN
    dfrm_d      = dfrm_q;
`endif
    if (sample_s && onehot_s) begin
      case (sel_s)
        SEL_MIN_U: frame_d.min_u = digit_s;
        SEL_MIN_D: frame_d.min_d = digit_s;
        SEL_HRS_U: frame_d.hrs_u = digit_s;
        default:   frame_d.hrs_d = digit_s;
      endcase
      seen_d      = seen_q | sel_s;
      err_glyph_d = !glyph_ok_s;
      bad_d       = bad_q | !glyph_ok_s;
`ifdef SEG7_CAPTURE_DP_EN
      dfrm_d      = (dfrm_q & ~sel_s) | (sel_s & {4{sync2_q[0]}});
`endif
    end else if (sample_s && (sel_s != 4'b0000)) begin
      err_sel_d = 1'b1;
    end else begin
      err_sel_d = 1'b0;
    end

`ifdef SEG7_CAPTURE_DP_EN
    same_s    = (frame_d == shadow_q) && (dfrm_d == dshadow_q);
    dshadow_d = dshadow_q;
`else
    same_s    = (frame_d == shadow_q);
`endif
    complete_s = (seen_d == 4'b1111);
    good_s     = complete_s && !bad_d && time_in_range(frame_d);
    shadow_d   = shadow_q;
    match_d    = match_q;
    if (complete_s) begin
      seen_d = 4'b0000;
      bad_d  = 1'b0;
      if (!good_s) begin
        match_d = 3'd0;
      end else if (same_s) begin
        match_d = (match_q == 3'd7) ? 3'd7 : match_q + 3'd1;
      end else begin
        shadow_d = frame_d;
        match_d  = 3'd1;
`ifdef SEG7_CAPTURE_DP_EN
        dshadow_d = dfrm_d;
`endif
      end
    end else begin
      match_d = match_q;
    end

    tmo_d    = tmo_q;
    valid_d  = valid_q;
    out_d    = out_q;
    update_d = 1'b0;
    // A good frame in the same cycle as the timeout keeps the value valid
    if (good_s) begin
      tmo_d = {TW{1'b0}};
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      valid_d = 1'b0;
      match_d = 3'd0;
    end

`ifdef SEG7_CAPTURE_DP_EN
    dout_d = dout_q;
    diff_s = (shadow_d != out_q) || (dshadow_d != dout_q);
`else
    diff_s = (shadow_d != out_q);
`endif
    if (good_s && (match_d >= STABLE_MIN)) begin
      out_d    = shadow_d;
      valid_d  = 1'b1;
      update_d = diff_s || !valid_q;
`ifdef SEG7_CAPTURE_DP_EN
      dout_d   = dshadow_d;
`endif
    end else begin
      update_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 12'd0;
      sync2_q     <= 12'd0;
      prev_q      <= 12'd0;
      settle_q    <= 8'd0;
      sampled_q   <= 1'b0;
      seen_q      <= 4'd0;
      bad_q       <= 1'b0;
      frame_q     <= '0;
      shadow_q    <= '0;
      out_q       <= '0;
      match_q     <= 3'd0;
      tmo_q       <= {TW{1'b0}};
      valid_q     <= 1'b0;
      update_q    <= 1'b0;
      err_glyph_q <= 1'b0;
      err_sel_q   <= 1'b0;
`ifdef SEG7_CAPTURE_DP_EN
      dfrm_q      <= 4'd0;
      dshadow_q   <= 4'd0;
      dout_q      <= 4'd0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      settle_q    <= settle_d;
      sampled_q   <= sampled_d;
      seen_q      <= seen_d;
      bad_q       <= bad_d;
      frame_q     <= frame_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      match_q     <= match_d;
      tmo_q       <= tmo_d;
      valid_q     <= valid_d;
      update_q    <= update_d;
      err_glyph_q <= err_glyph_d;
      err_sel_q   <= err_sel_d;
`ifdef SEG7_CAPTURE_DP_EN
      dfrm_q      <= dfrm_d;
      dshadow_q   <= dshadow_d;
      dout_q      <= dout_d;
`endif
    end
  end

  assign min_u      = out_q.min_u;
  assign min_d      = out_q.min_d;
  assign hrs_u      = out_q.hrs_u;
  assign hrs_d      = out_q.hrs_d;
  assign time_valid = valid_q;
  assign update     = update_q;
  assign err_glyph  = err_glyph_q;
  assign err_sel    = err_sel_q;
`ifdef SEG7_CAPTURE_DP_EN
  assign dots       = dout_q;
`endif

endmodule

// File: tb/tb_seg7_mux_capture.sv
// Bench for seg7_mux_capture: scenario table plus hand sequences, update scoreboard.
module tb_seg7_mux_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg_in;
  logic       dp_in;
  logic [3:0] sel_in;
  logic       seg_active_low, sel_active_low;
  logic [3:0] min_u, min_d, hrs_u, hrs_d;
  logic       time_valid, update, err_glyph, err_sel;
  logic [15:0] out_s;

  seg7_mux_capture dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .dp_in(dp_in), .sel_in(sel_in),
    .seg_active_low(seg_active_low), .sel_active_low(sel_active_low),
    .min_u(min_u), .min_d(min_d), .hrs_u(hrs_u), .hrs_d(hrs_d),
    .time_valid(time_valid), .update(update), .err_glyph(err_glyph), .err_sel(err_sel)
  );

  always #5 clk = ~clk;
  assign out_s = {hrs_d, hrs_u, min_d, min_u};

  typedef struct {
    logic [15:0] t;
    logic        pol;
    logic        bad_first;
    int          scans;
    logic        exp_valid;
    logic [15:0] exp_out;
    int          exp_upd;
    int          exp_errg;
  } vec_t;

  vec_t        vecs [7];
  logic [6:0]  glyph_tbl [10];
  logic [15:0] exp_q [$];
  int          checks = 0, errors = 0;
  int          n_upd = 0, n_errg = 0, n_errs = 0;
  logic        cur_pol = 1'b0;
  logic [15:0] m_shadow, m_pub;
  int          m_match;
  logic        m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each update pulse must match the oldest predicted publish
  always @(negedge clk) begin
    if (!reset) begin
      if (update) begin
        n_upd++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL update_unexpected: got %0h expected no update", out_s);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (out_s !== e || time_valid !== 1'b1) begin
            errors++;
            $display("FAIL update_value: got %0h valid %0b expected %0h valid 1",
                     out_s, time_valid, e);
          end
        end
      end
      if (err_glyph) n_errg++;
      if (err_sel)   n_errs++;
    end
  end

  task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input int n);
    sel_in = sel ^ {4{cur_pol}};
    seg_in = seg ^ {7{cur_pol}};
    dp_in  = cur_pol;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_digits", out_s, 16'h0000);
    chk("rst_valid", time_valid, 1'b0);
    chk("rst_pulses", {update, err_glyph, err_sel}, 3'b000);
    m_shadow = 16'h0000; m_pub = 16'h0000; m_match = 0; m_valid = 1'b0;
    exp_q.delete();
    n_upd = 0; n_errg = 0; n_errs = 0;
  endtask

  // Reference stability model, applied when the completing slot is driven
  task automatic model_frame(input logic [15:0] t, input logic bad);
    int   hrs;
    logic good;
    hrs  = int'(t[15:12]) * 10 + int'(t[11:8]);
    good = !bad && (hrs <= 23) && (t[7:4] <= 4'd5);
    if (!good) m_match = 0;
    else if (t == m_shadow) begin
      if (m_match < 7) m_match++;
    end else begin
      m_shadow = t;
      m_match  = 1;
    end
    if (good && m_match >= 2) begin
      if (!m_valid || t != m_pub) exp_q.push_back(t);
      m_pub   = t;
      m_valid = 1'b1;
    end
  endtask

  task automatic scan(input logic [15:0] t, input logic bad_mu, input int start);
    logic [15:0] tv;
    logic [6:0]  g;
    int          slot;
    tv = t;
    for (int k = 0; k < 4; k++) begin
      slot = (start + k) % 4;
      if (k == 3) model_frame(t, bad_mu);
      g = glyph_tbl[tv[4*slot +: 4]];
      if (bad_mu && slot == 0) g = 7'b0000001;
      drive(4'b0001 << slot, g, 40);
    end
  endtask

  initial begin
    reset = 1'b1; seg_in = 7'd0; dp_in = 1'b0; sel_in = 4'd0;
    seg_active_low = 1'b0; sel_active_low = 1'b0;
    glyph_tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                  7'b1101101, 7'b1111100, 7'b0000111, 7'b1111111, 7'b1100111};
    //          time      pol   badf  scans valid  out       upd errg
    vecs[0] = '{16'h1234, 1'b0, 1'b0, 3, 1'b1, 16'h1234, 1, 0};
    vecs[1] = '{16'h2359, 1'b1, 1'b0, 3, 1'b1, 16'h2359, 1, 0};
    vecs[2] = '{16'h0715, 1'b0, 1'b1, 3, 1'b1, 16'h0715, 1, 1};
    vecs[3] = '{16'h2500, 1'b0, 1'b0, 3, 1'b0, 16'h0000, 0, 0};
    vecs[4] = '{16'h0000, 1'b0, 1'b0, 2, 1'b1, 16'h0000, 1, 0};
    vecs[5] = '{16'h2400, 1'b0, 1'b0, 3, 1'b0, 16'h0000, 0, 0};
    vecs[6] = '{16'h1560, 1'b0, 1'b0, 3, 1'b0, 16'h0000, 0, 0};

    for (int i = 0; i < 7; i++) begin
      cur_pol = vecs[i].pol;
      seg_active_low = cur_pol;
      sel_active_low = cur_pol;
      drive(4'd0, 7'd0, 5);
      do_reset();
      for (int s = 0; s < vecs[i].scans; s++) begin
        scan(vecs[i].t, vecs[i].bad_first && s == 0, 0);
        chk($sformatf("v%0d_scan%0d_valid", i, s), time_valid, m_valid);
      end
      drive(4'd0, 7'd0, 10);
      chk($sformatf("v%0d_valid", i), time_valid, vecs[i].exp_valid);
      chk($sformatf("v%0d_digits", i), out_s, vecs[i].exp_out);
      chk($sformatf("v%0d_updates", i), n_upd, vecs[i].exp_upd);
      chk($sformatf("v%0d_err_glyph", i), n_errg, vecs[i].exp_errg);
      chk($sformatf("v%0d_err_sel", i), n_errs, 0);
      chk($sformatf("v%0d_sb_empty", i), exp_q.size(), 0);
    end

    // Multi-hot selector, then publish and let the display go silent
    cur_pol = 1'b0; seg_active_low = 1'b0; sel_active_low = 1'b0;
    drive(4'd0, 7'd0, 5);
    do_reset();
    drive(4'b0110, glyph_tbl[1], 10);
    drive(4'd0, 7'd0, 10);
    chk("sel_err_count", n_errs, 1);
    chk("sel_err_noupd", n_upd, 0);
    scan(16'h1234, 1'b0, 0);
    scan(16'h1234, 1'b0, 0);
    chk("pre_tmo_valid", time_valid, 1'b1);
    drive(4'd0, 7'd0, 900);
    chk("tmo_not_yet", time_valid, 1'b1);
    drive(4'd0, 7'd0, 200);
    chk("tmo_valid", time_valid, 1'b0);
    chk("tmo_hold", out_s, 16'h1234);
    m_valid = 1'b0; m_match = 0;
    scan(16'h1234, 1'b0, 0);
    chk("tmo_rescan1_valid", time_valid, 1'b0);
    scan(16'h1234, 1'b0, 0);
    chk("tmo_rescan2_valid", time_valid, 1'b1);
    chk("tmo_updates", n_upd, 2);
    chk("tmo_err_sel", n_errs, 1);

    // Reset with two slots of a scan seen; partial frame must be dropped
    do_reset();
    scan(16'h1234, 1'b0, 0);
    scan(16'h1234, 1'b0, 0);
    chk("mid_pre_valid", time_valid, 1'b1);
    drive(4'b0001, glyph_tbl[4], 40);
    drive(4'b0010, glyph_tbl[3], 40);
    do_reset();
    scan(16'h1234, 1'b0, 2);
    chk("mid_scan1_valid", time_valid, 1'b0);
    scan(16'h1234, 1'b0, 2);
    drive(4'd0, 7'd0, 10);
    chk("mid_scan2_valid", time_valid, 1'b1);
    chk("mid_digits", out_s, 16'h1234);
    chk("mid_updates", n_upd, 1);
    chk("mid_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_mux_capture.md
# seg7_mux_capture

Receiving end of the multiplexed 7-segment display bus: samples the one-hot digit selector, the segment lines and the decimal point, decodes each settled glyph back to BCD, and assembles 4-digit HH:MM frames. A frame is published only after it repeats identically for a set number of consecutive scans. The block sits on the bench/companion-chip side to read back a running clock display, and doubles as a self-checking monitor in the top-level testbench.

## Interface
- `SETTLE_CYCLES`, default 4: cycles selector and segments must hold unchanged before a digit is sampled (1..255).
- `STABLE_FRAMES`, default 2: consecutive identical complete frames required to publish (1..7).
- `TIMEOUT_CYCLES`, default 1024: cycles without a complete good frame before `time_valid` drops (≥16).
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `seg_in`  in  7  segment lines, bit0 = a … bit6 = g; asynchronous.
- `dp_in`  in  1  decimal-point line; asynchronous.
- `sel_in`  in  4  digit selector; bit0 = min_u, bit1 = min_d, bit2 = hrs_u, bit3 = hrs_d; asynchronous.
- `seg_active_low`  in  1  1: `seg_in`/`dp_in` are inverted on the wire; quasi-static.
- `sel_active_low`  in  1  1: `sel_in` is inverted on the wire; quasi-static.
- `min_u`, `min_d`, `hrs_u`, `hrs_d`  out  4 each  published BCD digits.
- `dots`  out  4  published decimal points (bit order as `sel_in`); only with `SEG7_CAPTURE_DP_EN`.
- `time_valid`  out  1  published value is current.
- `update`  out  1  one-cycle pulse when the published digits change.
- `err_glyph`  out  1  one-cycle pulse when an undecodable glyph is sampled.
- `err_sel`  out  1  one-cycle pulse when a non-one-hot, non-zero selector settles.

## Operation
- Input stage: XOR with the polarity bits, then a 2-flop synchronizer on all 12 lines.
- Settle counter: reset to 0 whenever the synchronized `{sel, seg, dp}` differs from the previous cycle. Otherwise increments, saturating at `SETTLE_CYCLES`.
- Sampling: when the counter reaches `SETTLE_CYCLES`, a digit is sampled once. It is not sampled again until the selector changes.
  - One-hot selector: write the decoded digit into the slot, set its `seen` bit.
  - Selector 0000: ignored silently.
  - Any other selector value: ignored and `err_sel` pulses.
- Glyph map, `seg` value to digit:
  - 0111111=0, 0000110=1, 1011011=2, 1001111=3, 1100110=4
  - 1101101=5, 1111100=6, 0000111=7, 1111111=8, 1100111=9
  - Any other pattern: `err_glyph` pulses and the current frame is marked bad.
- Frame completion: when `seen` becomes 1111, the frame is complete. Then clear `seen` and the bad flag.
  - A slot sampled twice before completion is overwritten.
- Range check at completion: `min_d` ≤ 5, `min_u` ≤ 9, hours ≤ 23. An out-of-range frame is treated as bad.
- Stability logic:
  - Bad frame: clears `match_cnt` and is not stored.
  - Good frame equal to `shadow`: `match_cnt` increments, saturating at 7.
  - Good frame not equal to `shadow`: store it in `shadow`, set `match_cnt` = 1.
- Publish: when `match_cnt` ≥ `STABLE_FRAMES`, copy `shadow` to the outputs and set `time_valid` = 1. Pulse `update` only if the copied value differs from the current output, or `time_valid` was 0.
- Timeout counter:
  - Cleared on every good complete frame; saturates at `TIMEOUT_CYCLES`.
  - On reaching `TIMEOUT_CYCLES`: `time_valid` = 0. Digits keep their last value and `match_cnt` is cleared.
- Reset: all outputs, `shadow`, `seen`, counters and flags go to 0, and the synchronizers are flushed to 0. Reset mid-frame discards any partial frame.

## Timing
- Wire-to-synchronized latency: 2 cycles.
- Sample cycle: the cycle after `SETTLE_CYCLES` consecutive unchanged synchronized cycles.
- `err_glyph` and `err_sel` pulse in the sample cycle.
- Digit outputs, `time_valid` and `update` change 1 cycle after the completing sample.
- `STABLE_FRAMES` = 1: the first good frame publishes.
- Selector change and glyph change in the same cycle: one change, settle restarts once.
- Timeout and a completing good frame in the same cycle: the good frame wins and `time_valid` stays 1.
- Polarity inputs are sampled through the synchronizer. Toggling them mid-scan corrupts at most the current frame.

## Configuration
- `SEG7_CAPTURE_DP_EN` defined:
  - `dp` is stored per slot and the `dots` port exists.
  - `dots` is part of frame equality and of the change detection for `update`.
- `SEG7_CAPTURE_DP_EN` undefined:
  - No `dots` port; `dp_in` is an unused input.
  - `dp` still takes part in the settle comparison.

## Structure
- Package `seg7_pkg`:
  - The ten glyph constants and `SEG7_BLANK` = 0000000.
  - Selector one-hot constants `SEL_MIN_U` … `SEL_HRS_D`.
  - A 16-bit `bcd_time_t` frame type.
- Sub-module `seg7_decode`: combinational glyph to `{valid, digit[3:0]}`, shared with the display-driver bench.

## Test plan
- Active-high lines; scan 12:34 with 40 cycles per digit for 3 scans (`STABLE_FRAMES` = 2) → after scan 2, `hrs_d`=1, `hrs_u`=2, `min_d`=3, `min_u`=4; `time_valid`=1; exactly one `update` pulse.
- Both polarity bits = 1 and inverted wires showing 23:59 → decodes 23:59; no error pulses.
- Glyph 0000001 on the `min_u` slot in scan 1, correct 07:15 afterwards → one `err_glyph` pulse; publish occurs only after 2 further good scans.
- Scan 25:00 three times → no publish; `time_valid` stays 0.
- Selector 0110 held 10 cycles → one `err_sel` pulse, no slot written. Then stop scanning for 1024 cycles after a valid publish → `time_valid`=0, digits hold.
- `reset` asserted mid-scan (2 of 4 slots seen) → all outputs 0; the next full scans publish normally.
